// File: rtl/pipe_ctrl_if.sv
// Data-memory request bus between the pipeline controller and the memory.
// The controller drives req/we; the memory answers with gnt/rvalid.
interface pipe_ctrl_if;
    logic req;
    logic we;
    logic gnt;
    logic rvalid;

    modport master (
        output req,
        output we,
        input  gnt,
        input  rvalid
    );

    modport slave (
        input  req,
        input  we,
        output gnt,
        output rvalid
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Sequencing controller for the 3-stage core (IF, DX, MW).
// Keeps a shadow of the MW stage, stalls the pipe while a load/store is
// outstanding (with a timeout into a sticky error state), redirects the PC
// for jumps/taken branches and selects MW->DX operand forwarding.
// Optional: define PIPE_PERF_CNT_EN to add saturating stall/flush counters.
//
// state  | meaning
// RUN    | pipeline flowing; a mem op in MW may complete in its first cycle
// REQ    | mem op in MW still waiting for dmem_gnt, request held
// WAIT_R | load granted, waiting for dmem_rvalid, request dropped
// ERR    | memory timeout; pipe frozen until reset
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid_d,
    input  logic        mem_access_d,
    input  logic        reg_write_d,
    input  logic [1:0]  wb_sel_d,
    input  logic        branch_d,
    input  logic        jop_d,
    input  logic        pc_sel_bit0_d,
    input  logic [4:0]  adr1_d,
    input  logic [4:0]  adr2_d,
    input  logic [4:0]  rd_d,
    input  logic        br_taken,
    pipe_ctrl_if.master dmem,
    output logic        stall,
    output logic        flush_if,
    output logic [1:0]  pc_sel,
    output logic        fwd_a,
    output logic        fwd_b,
    output logic        mem_err
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    // Timeout is a down-counter loaded on entry to REQ/WAIT_R; reaching zero
    // without the exit event means the op has used up all its cycles.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt_dec;

    logic       mw_valid;
    logic [4:0] mw_rd;
    logic       mw_rw;
    logic       mw_mem;
    logic       mw_ld;

    logic mem_op;
    logic mw_st;
    logic req_done;

    // Request-side decode and stall; stall must react to gnt/rvalid in the
    // same cycle so the pipe is released on the completing cycle.
    always_comb begin
        mem_op   = mw_valid & mw_mem;
        mw_st    = mw_mem & ~mw_ld;
        req_done = dmem.gnt & (mw_st | dmem.rvalid);
        cnt_tc   = (cnt == '0);
        cnt_dec  = cnt_tc ? cnt : cnt - 1'b1;
        stall    = 1'b0;
        dmem.req = 1'b0;
        case (state)
            ST_RUN: begin
                stall    = mem_op & ~req_done;
                dmem.req = mem_op;
            end
            ST_REQ: begin
                stall    = ~req_done;
                dmem.req = mem_op;
            end
            ST_WAIT_R: stall = ~dmem.rvalid;
            default:   stall = 1'b1;
        endcase
        dmem.we = dmem.req & mw_st;
    end

    // Forwarding from the MW writeback value; valid regardless of stall.
    always_comb begin
        fwd_a = mw_valid & mw_rw & (mw_rd != 5'd0) & (mw_rd == adr1_d);
        fwd_b = mw_valid & mw_rw & (mw_rd != 5'd0) & (mw_rd == adr2_d);
    end

    // Next-PC select; a redirect in DX is held off while the pipe is stalled.
    always_comb begin
        pc_sel   = 2'b00;
        flush_if = 1'b0;
        if (instr_valid_d && !stall) begin
            if (jop_d) begin
                pc_sel   = 2'b10;
                flush_if = 1'b1;
            end else if (pc_sel_bit0_d || (branch_d && br_taken)) begin
                pc_sel   = 2'b01;
                flush_if = 1'b1;
            end
        end
    end

    // Memory-wait FSM, timeout counter and MW shadow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            cnt      <= '0;
            mem_err  <= 1'b0;
            mw_valid <= 1'b0;
            mw_rd    <= 5'd0;
            mw_rw    <= 1'b0;
            mw_mem   <= 1'b0;
            mw_ld    <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_op) begin
                        if (!dmem.gnt) begin
                            state <= ST_REQ;
                            cnt   <= CNT_LOAD;
                        end else if (mw_ld && !dmem.rvalid) begin
                            state <= ST_WAIT_R;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem.gnt) begin
                        if (mw_ld && !dmem.rvalid) begin
                            state <= ST_WAIT_R;
                            cnt   <= cnt_dec;
                        end else begin
                            state <= ST_RUN;
                        end
                    end else if (cnt_tc) begin
                        state   <= ST_ERR;
                        mem_err <= 1'b1;
                    end else begin
                        cnt <= cnt_dec;
                    end
                end
                ST_WAIT_R: begin
                    if (dmem.rvalid) begin
                        state <= ST_RUN;
                    end else if (cnt_tc) begin
                        state   <= ST_ERR;
                        mem_err <= 1'b1;
                    end else begin
                        cnt <= cnt_dec;
                    end
                end
                default: begin
                    state   <= ST_ERR;
                    mem_err <= 1'b1;
                end
            endcase

            if (!stall) begin
                mw_valid <= instr_valid_d;
                mw_rd    <= rd_d;
                mw_rw    <= reg_write_d;
                mw_mem   <= mem_access_d;
                mw_ld    <= mem_access_d & (wb_sel_d == 2'b01);
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // Saturating event counters for stall and IF-flush cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (stall && (perf_stall_cnt != 32'hFFFF_FFFF))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flush_if && (perf_flush_cnt != 32'hFFFF_FFFF))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl: a reference model of the memory handshake
// and control-flow rules pushes one expected output vector per cycle into a
// scoreboard queue; a monitor on the falling edge pops and compares.
module tb_pipe_ctrl;
    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 5;

    typedef struct packed {
        logic       stall;
        logic       flush_if;
        logic [1:0] pc_sel;
        logic       fwd_a;
        logic       fwd_b;
        logic       req;
        logic       we;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid_d, mem_access_d, reg_write_d;
    logic [1:0] wb_sel_d;
    logic       branch_d, jop_d, pc_sel_bit0_d;
    logic [4:0] adr1_d, adr2_d, rd_d;
    logic       br_taken, gnt, rvalid;
    logic       stall, flush_if, fwd_a, fwd_b, mem_err;
    logic [1:0] pc_sel;

    pipe_ctrl_if dmem_bus ();
    assign dmem_bus.gnt    = gnt;
    assign dmem_bus.rvalid = rvalid;

    pipe_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid_d (instr_valid_d),
        .mem_access_d  (mem_access_d),
        .reg_write_d   (reg_write_d),
        .wb_sel_d      (wb_sel_d),
        .branch_d      (branch_d),
        .jop_d         (jop_d),
        .pc_sel_bit0_d (pc_sel_bit0_d),
        .adr1_d        (adr1_d),
        .adr2_d        (adr2_d),
        .rd_d          (rd_d),
        .br_taken      (br_taken),
        .dmem          (dmem_bus.master),
        .stall         (stall),
        .flush_if      (flush_if),
        .pc_sel        (pc_sel),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    exp_t sb[$];

    // Reference model state: what sits in MW and how far its memory op got.
    logic       m_valid, m_rw, m_mem, m_ld;
    logic [4:0] m_rd;
    logic       m_err;
    logic       m_granted;
    int         m_phase;
    logic       cur_complete, cur_stall;
    exp_t       e_cur;

    function automatic exp_t actual_vec();
        exp_t a;
        a = '{stall, flush_if, pc_sel, fwd_a, fwd_b, dmem_bus.req, dmem_bus.we, mem_err};
        return a;
    endfunction

    task automatic check_vec(input string name, input exp_t act, input exp_t exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s t=%0t actual=%b expected=%b (stall,flush,pc_sel,fa,fb,req,we,err)",
                      name, $time, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && sb.size() > 0) check_vec("cycle", actual_vec(), sb.pop_front());
    end

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mem = 0; m_ld = 0; m_rd = 0;
        m_err = 0; m_granted = 0; m_phase = 0;
    endtask

    task automatic model_eval();
        logic is_store;
        e_cur = '0;
        cur_complete = 1'b0;
        is_store = m_mem && !m_ld;
        if (m_err) begin
            e_cur.stall = 1'b1;
            e_cur.err   = 1'b1;
        end else if (m_valid && m_mem) begin
            if (!m_granted) begin
                e_cur.req = 1'b1;
                e_cur.we  = is_store;
            end
            cur_complete = is_store ? gnt : ((m_granted || gnt) && rvalid);
            e_cur.stall  = !cur_complete;
        end
        cur_stall = e_cur.stall;
        e_cur.fwd_a = m_valid && m_rw && (m_rd != 0) && (m_rd == adr1_d);
        e_cur.fwd_b = m_valid && m_rw && (m_rd != 0) && (m_rd == adr2_d);
        if (instr_valid_d && !cur_stall) begin
            if (jop_d) begin
                e_cur.pc_sel = 2'b10; e_cur.flush_if = 1'b1;
            end else if (pc_sel_bit0_d || (branch_d && br_taken)) begin
                e_cur.pc_sel = 2'b01; e_cur.flush_if = 1'b1;
            end
        end
    endtask

    task automatic model_update();
        logic exit_ev;
        if (!m_err && m_valid && m_mem) begin
            if (cur_complete) begin
                m_granted = 0;
                m_phase   = 0;
            end else begin
                exit_ev = m_granted ? rvalid : gnt;
                // phase 0 is the RUN cycle; waiting cycles are phase 1..MEM_TIMEOUT
                if (m_phase >= MEM_TIMEOUT && !exit_ev) m_err = 1;
                m_granted = m_granted | gnt;
                m_phase++;
            end
        end
        if (!cur_stall) begin
            m_valid = instr_valid_d;
            m_rd    = rd_d;
            m_rw    = reg_write_d;
            m_mem   = mem_access_d;
            m_ld    = mem_access_d && (wb_sel_d == 2'b01);
        end
    endtask

    task automatic inputs_zero();
        instr_valid_d = 0; mem_access_d = 0; reg_write_d = 0; wb_sel_d = 0;
        branch_d = 0; jop_d = 0; pc_sel_bit0_d = 0; adr1_d = 0; adr2_d = 0;
        rd_d = 0; br_taken = 0; gnt = 0; rvalid = 0;
    endtask

    task automatic drive(input bit force_ld);
        instr_valid_d = ($urandom_range(0, 3) != 0);
        mem_access_d  = ($urandom_range(0, 2) == 0);
        reg_write_d   = 1'($urandom_range(0, 1));
        wb_sel_d      = 2'($urandom_range(0, 3));
        branch_d      = ($urandom_range(0, 3) == 0);
        jop_d         = ($urandom_range(0, 7) == 0);
        pc_sel_bit0_d = ($urandom_range(0, 7) == 0);
        adr1_d        = 5'($urandom_range(0, 7));
        adr2_d        = 5'($urandom_range(0, 7));
        rd_d          = 5'($urandom_range(0, 7));
        br_taken      = 1'($urandom_range(0, 1));
        gnt           = ($urandom_range(0, 9) < 6);
        rvalid        = 1'($urandom_range(0, 1));
        if (force_ld) begin
            instr_valid_d = 1; mem_access_d = 1; wb_sel_d = 2'b01;
            gnt = 0; rvalid = 0;
        end
    endtask

    task automatic step(input bit force_ld);
        drive(force_ld);
        model_eval();
        sb.push_back(e_cur);
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Asynchronous reset pulse in mid-cycle; outputs must clear immediately.
    task automatic reset_pulse();
        @(negedge clk);
        #2;
        inputs_zero();
        rst_n = 0;
        #1;
        check_vec("async_reset", actual_vec(), exp_t'(0));
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1;
    endtask

    initial begin
        inputs_zero();
        model_reset();
        rst_n = 0;
        #1;
        check_vec("reset_state", actual_vec(), exp_t'(0));
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 300; i++) step(1'b0);
            for (int i = 0; i < MEM_TIMEOUT + 9; i++) step(1'b1);
            checks++;
            if (m_err) passes++;
            else $display("FAIL timeout_model actual=%0d expected=1", m_err);
            reset_pulse();
            for (int i = 0; i < 10; i++) step(1'b0);
            for (int i = 0; i < 6; i++) step(1'b1);
            reset_pulse();
        end
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() == 0) passes++;
        else $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Sequencing controller for the 3-stage core (IF, DX, MW). It takes the decoded control bits of the instruction in DX and keeps a shadow copy of the MW stage. It generates stalls, IF flushes, next-PC select, operand forwarding selects and the data-memory request handshake. A memory-wait FSM with a timeout freezes the pipeline while a load or store is outstanding.

Parameters:
MEM_TIMEOUT, 16, cycles a memory op may stay in REQ/WAIT_R before entering ERR (minimum 2)
CNT_W, 5, width of timeout counter; must satisfy 2^CNT_W > MEM_TIMEOUT

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  reset; asynchronous assert, active-low
instr_valid_d  in  1  DX holds a live instruction
mem_access_d  in  1  DX instruction is a load or store
reg_write_d  in  1  DX instruction writes rd
wb_sel_d  in  2  DX writeback select (01 = load data)
branch_d / jop_d / pc_sel_bit0_d  in  1 each  conditional branch / JALR / JAL-or-JALR
adr1_d, adr2_d, rd_d  in  5 each  DX source and destination register addresses
br_taken  in  1  branch comparator result for DX this cycle
dmem_gnt  in  1  memory accepted request this cycle
dmem_rvalid  in  1  load data valid this cycle
stall  out  1  hold PC, IF/DX and DX/MW pipeline registers
flush_if  out  1  kill the instruction in IF (becomes DX bubble)
pc_sel  out  2  00 PC+4, 01 JAL/branch target, 10 JALR target
fwd_a, fwd_b  out  1 each  take operand A/B from MW writeback value
dmem_req  out  1  memory request valid
dmem_we  out  1  request is a store
mem_err  out  1  sticky memory timeout flag

Behaviour:
- Reset (rst_n=0, async): state=RUN, shadow MW cleared (mw_valid=0), counter=0. All outputs 0, pc_sel=00. dmem_req drops immediately, including mid-transaction.
- MW shadow: updated on every clk edge with stall=0.
  - mw_valid<=instr_valid_d; mw_rd<=rd_d; mw_rw<=reg_write_d; mw_mem<=mem_access_d.
  - mw_ld<=mem_access_d&(wb_sel_d==01); store = mw_mem&!mw_ld.
  - A flushed IF slot arrives as instr_valid_d=0.
- Memory request: dmem_req=mw_valid&mw_mem in RUN and REQ; dmem_we=store whenever dmem_req is high.
- FSM:
  - RUN, no memory op in MW: stall=0.
  - RUN, mem op, store with gnt: no stall.
  - RUN, mem op, load with gnt&rvalid in the same cycle: no stall.
  - RUN, mem op, load with gnt but no rvalid: ->WAIT_R, stall=1.
  - RUN, mem op, no gnt: ->REQ, stall=1.
  - REQ: dmem_req held, stall=1. On gnt: store->RUN (stall released this cycle); load with rvalid->RUN; load without rvalid->WAIT_R.
  - WAIT_R: dmem_req=0, stall=1. On rvalid->RUN with stall=0 that cycle.
  - ERR: stall=1, dmem_req=0, mem_err=1. Exit only by reset.
- Timeout: counter clears on entry to REQ/WAIT_R and increments each cycle spent there (the REQ->WAIT_R transition does not clear it). When counter==MEM_TIMEOUT-1 and the exit event is absent -> ERR. An exit event on that same cycle wins.
- Forwarding: fwd_a = mw_valid&mw_rw&(mw_rd!=0)&(mw_rd==adr1_d); fwd_b uses adr2_d. Purely combinational; valid even during stall. No load-use bubble, because loads stall in MW until data returns.
- Control flow, evaluated only when instr_valid_d&!stall; otherwise pc_sel=00, flush_if=0.
  - jop_d: pc_sel=10, flush_if=1.
  - else pc_sel_bit0_d: pc_sel=01, flush_if=1.
  - else branch_d&br_taken: pc_sel=01, flush_if=1.
  - else: pc_sel=00, flush_if=0.
- Simultaneous: a taken branch in DX while MW stalls is held (no redirect) and resolves on the first unstalled cycle.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt counts cycles with stall=1; perf_flush_cnt counts cycles with flush_if=1.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Store, gnt in same cycle: no stall cycle; dmem_req=1, dmem_we=1 for one cycle.
- Load to x5; gnt at cycle 0, rvalid at cycle 3 -> state REQ? no, WAIT_R; stall=1 for 3 cycles and 0 on the rvalid cycle; next ADD x6,x5,x5 sees fwd_a=fwd_b=1.
- Load with gnt withheld 20 cycles, MEM_TIMEOUT=16 -> mem_err=1 after 16 stalled cycles; stall stays 1; rst_n pulse clears mem_err and drops dmem_req asynchronously.
- BEQ with br_taken=1 -> pc_sel=01, flush_if=1 for one cycle. JALR -> pc_sel=10. BNE with br_taken=0 -> pc_sel=00.
- Taken branch in DX while a load waits in WAIT_R -> pc_sel=00 during stall; redirect (pc_sel=01, flush_if=1) on the rvalid cycle.
- rd=x0 in MW with adr1_d=0 -> fwd_a=0. rd=x7, adr2_d=7, reg_write=1 -> fwd_b=1.
